// File: rtl/i2c_sram_master.sv
// I2C master for a 16-bit word SRAM slave: one START, device byte, word
// address, two data bytes (written or read back), then STOP and a response.
module i2c_sram_master #(
   parameter int CLK_DIV        = 4,
   parameter bit CHECK_DATA_ACK = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rw,
   input  logic [6:0]  cmd_dev_addr,
   input  logic [7:0]  cmd_mem_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_nack,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        scl,
   inout  wire         sda
);

   // state       | meaning
   // IDLE        | waiting for a command, bus released
   // START       | START condition slot
   // DEV         | 7-bit device address + mode bit
   // DEV_ACK     | slave ACK of device byte (NACK always aborts)
   // MADDR       | SRAM word address byte
   // MADDR_ACK   | slave ACK of address byte
   // WR_HI/WR_LO | write data bytes, high first
   // WR_*_ACK    | slave ACK of write data
   // RD_HI/RD_LO | read data bytes from slave
   // RD_HI_MACK  | master ACK after high byte
   // RD_LO_MACK  | master NACK after low byte
   // STOP        | STOP condition slot
   // DONE        | one-clk response pulse
   typedef enum logic [3:0] {
      IDLE, START, DEV, DEV_ACK, MADDR, MADDR_ACK, WR_HI, WR_HI_ACK,
      WR_LO, WR_LO_ACK, RD_HI, RD_HI_MACK, RD_LO, RD_LO_MACK, STOP, DONE
   } state_t;

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   state_t        state_q, state_d;
   logic [QW-1:0] q_cnt;
   logic [1:0]    phase;
   logic [2:0]    bit_cnt;
   logic          rw_q;
   logic [6:0]    dev_q;
   logic [7:0]    mem_q;
   logic [15:0]   wdata_q;
   logic [15:0]   rx_q;
   logic [15:0]   rdata_q;
   logic          smp_q;
   logic          nack_q;
   logic          abort;
   logic          sda_low;
   logic [7:0]    tx_byte;
   logic          is_byte;

   wire accept   = cmd_valid && (state_q == IDLE);
   wire slot_end = (q_cnt == Q_LAST) && (phase == 2'd3);
   wire smp_pt   = (q_cnt == Q_LAST) && (phase == 2'd2);
   wire byte_end = slot_end && (bit_cnt == 3'd7);

   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         IDLE:       if (cmd_valid) state_d = START;
         START:      if (slot_end) state_d = DEV;
         DEV:        if (byte_end) state_d = DEV_ACK;
         DEV_ACK:    if (slot_end) begin
                        abort   = smp_q;
                        state_d = smp_q ? STOP : MADDR;
                     end
         MADDR:      if (byte_end) state_d = MADDR_ACK;
         MADDR_ACK:  if (slot_end) begin
                        abort = CHECK_DATA_ACK && smp_q;
                        if (abort)     state_d = STOP;
                        else if (rw_q) state_d = RD_HI;
                        else           state_d = WR_HI;
                     end
         WR_HI:      if (byte_end) state_d = WR_HI_ACK;
         WR_HI_ACK:  if (slot_end) begin
                        abort   = CHECK_DATA_ACK && smp_q;
                        state_d = abort ? STOP : WR_LO;
                     end
         WR_LO:      if (byte_end) state_d = WR_LO_ACK;
         WR_LO_ACK:  if (slot_end) begin
                        abort   = CHECK_DATA_ACK && smp_q;
                        state_d = STOP;
                     end
         RD_HI:      if (byte_end) state_d = RD_HI_MACK;
         RD_HI_MACK: if (slot_end) state_d = RD_LO;
         RD_LO:      if (byte_end) state_d = RD_LO_MACK;
         RD_LO_MACK: if (slot_end) state_d = STOP;
         STOP:       if (slot_end) state_d = DONE;
         DONE:       state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      is_byte = 1'b0;
      scl     = 1'b1;
      sda_low = 1'b0;
      case (state_q)
         DEV:   tx_byte = {dev_q, rw_q};
         MADDR: tx_byte = mem_q;
         WR_HI: tx_byte = wdata_q[15:8];
         WR_LO: tx_byte = wdata_q[7:0];
         default: tx_byte = 8'h00;
      endcase
      case (state_q)
         START: begin
            scl     = (phase != 2'd3);
            sda_low = (phase != 2'd0);
         end
         STOP: begin
            scl     = (phase != 2'd0);
            sda_low = !phase[1];
         end
         DEV, MADDR, WR_HI, WR_LO: begin
            is_byte = 1'b1;
            scl     = phase[1];
            sda_low = !tx_byte[~bit_cnt];
         end
         RD_HI, RD_LO: begin
            is_byte = 1'b1;
            scl     = phase[1];
         end
         RD_HI_MACK: begin
            scl     = phase[1];
            sda_low = 1'b1;
         end
         DEV_ACK, MADDR_ACK, WR_HI_ACK, WR_LO_ACK, RD_LO_MACK: scl = phase[1];
         default: scl = 1'b1;
      endcase
   end

   assign sda       = sda_low ? 1'b0 : 1'bz;
   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_nack  = nack_q;
   assign rsp_rdata = rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         q_cnt   <= '0;
         phase   <= 2'd0;
         bit_cnt <= 3'd0;
         rw_q    <= 1'b0;
         dev_q   <= 7'h00;
         mem_q   <= 8'h00;
         wdata_q <= 16'h0000;
         rx_q    <= 16'h0000;
         rdata_q <= 16'h0000;
         smp_q   <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rw_q    <= cmd_rw;
            dev_q   <= cmd_dev_addr;
            mem_q   <= cmd_mem_addr;
            wdata_q <= cmd_wdata;
            nack_q  <= 1'b0;
            q_cnt   <= '0;
            phase   <= 2'd0;
            bit_cnt <= 3'd0;
         end else if (state_q != IDLE && state_q != DONE) begin
            // STOP's final wrap leaves every counter at zero for the next command
            if (q_cnt == Q_LAST) begin
               q_cnt <= '0;
               phase <= phase + 2'd1;
            end else begin
               q_cnt <= q_cnt + QW'(1);
            end
            if (slot_end && is_byte) bit_cnt <= bit_cnt + 3'd1;
         end
         if (smp_pt) smp_q <= sda;
         if (smp_pt && (state_q == RD_HI || state_q == RD_LO)) rx_q <= {rx_q[14:0], sda};
         if (abort) nack_q <= 1'b1;
         if (state_q == STOP && slot_end && rw_q && !nack_q) rdata_q <= rx_q;
      end
   end

endmodule

// File: tb/tb_i2c_sram_master.sv
// Directed bench for i2c_sram_master: two instances (data-ACK checking off/on),
// each with a small I2C SRAM-slave model that logs bus bytes and ACK bits.
module tb_i2c_sram_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid0, cmd_valid1;
   logic        cmd_rw;
   logic [6:0]  cmd_dev_addr;
   logic [7:0]  cmd_mem_addr;
   logic [15:0] cmd_wdata;
   logic        cmd_ready0, rsp_valid0, rsp_nack0, busy0, scl0;
   logic        cmd_ready1, rsp_valid1, rsp_nack1, busy1, scl1;
   logic [15:0] rsp_rdata0, rsp_rdata1;
   wire         sda0, sda1;

   int total = 0;
   int bad   = 0;

   logic [3:0]  ack_en   [2];
   logic [15:0] sl_rdata [2];

   pullup (sda0);
   pullup (sda1);

   always #5 clk = ~clk;

   i2c_sram_master #(.CLK_DIV(4), .CHECK_DATA_ACK(1'b0)) u_dut0 (
      .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid0), .rsp_nack(rsp_nack0),
      .rsp_rdata(rsp_rdata0), .busy(busy0), .scl(scl0), .sda(sda0)
   );

   i2c_sram_master #(.CLK_DIV(4), .CHECK_DATA_ACK(1'b1)) u_dut1 (
      .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid1), .rsp_nack(rsp_nack1),
      .rsp_rdata(rsp_rdata1), .busy(busy1), .scl(scl1), .sda(sda1)
   );

   // Slave model: samples the bus mid-cycle, acts on SCL edges and START/STOP.
   for (genvar b = 0; b < 2; b++) begin : g_slv
      logic       scl_b, sda_b;
      logic       drv      = 1'b0;
      logic       prev_scl = 1'b1;
      logic       prev_sda = 1'b1;
      logic       active   = 1'b0;
      logic       rd       = 1'b0;
      int         bitn     = 0;
      int         bytn     = 0;
      int         nbytes   = 0;
      int         nstops   = 0;
      logic [7:0] sh       = 8'h00;
      logic [7:0] bytes [4];
      logic       acks  [4];
      logic [7:0] rb_cur, rb_next;

      if (b == 0) begin : g_c0
         assign scl_b = scl0;
         assign sda_b = sda0;
         assign sda0  = drv ? 1'b0 : 1'bz;
      end else begin : g_c1
         assign scl_b = scl1;
         assign sda_b = sda1;
         assign sda1  = drv ? 1'b0 : 1'bz;
      end

      assign rb_cur  = (bytn == 2) ? sl_rdata[b][15:8] : sl_rdata[b][7:0];
      assign rb_next = (bytn + 1 == 2) ? sl_rdata[b][15:8] : sl_rdata[b][7:0];

      always @(negedge clk) begin
         if (prev_scl && scl_b && prev_sda && !sda_b) begin
            active <= 1'b1;
            bitn   <= 0;
            bytn   <= 0;
            nbytes <= 0;
            sh     <= 8'h00;
            drv    <= 1'b0;
            rd     <= 1'b0;
         end else if (prev_scl && scl_b && !prev_sda && sda_b) begin
            active <= 1'b0;
            drv    <= 1'b0;
            nstops <= nstops + 1;
         end else if (active && !prev_scl && scl_b) begin
            if (bitn < 8) sh <= {sh[6:0], sda_b};
            else if (bitn == 8 && bytn < 4) acks[bytn[1:0]] <= sda_b;
            bitn <= bitn + 1;
         end else if (active && prev_scl && !scl_b) begin
            if (bitn == 8) begin
               if (bytn < 4) bytes[bytn[1:0]] <= sh;
               nbytes <= bytn + 1;
               if (bytn == 0) rd <= sh[0];
               drv <= (bytn < 4) && !(rd && bytn >= 2) && ack_en[b][bytn[1:0]];
            end else if (bitn == 9) begin
               bitn <= 0;
               bytn <= bytn + 1;
               sh   <= 8'h00;
               drv  <= rd && (bytn + 1 == 2 || bytn + 1 == 3) && !rb_next[7];
            end else if (rd && bytn >= 2 && bytn <= 3 && bitn >= 1 && bitn <= 7) begin
               drv <= !rb_cur[3'(7 - bitn)];
            end
         end
         prev_scl <= scl_b;
         prev_sda <= sda_b;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rv(input int b);
      return (b == 0) ? rsp_valid0 : rsp_valid1;
   endfunction

   // Issues one command, scrambles the inputs after acceptance, and returns
   // the cycle (1 = first cycle after the accept edge) in which rsp_valid is seen.
   task automatic do_cmd(input int b, input logic rw, input logic [6:0] dev,
                         input logic [7:0] mem, input logic [15:0] wd, output int lat);
      @(negedge clk);
      cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = mem; cmd_wdata = wd;
      if (b == 0) cmd_valid0 = 1'b1; else cmd_valid1 = 1'b1;
      @(negedge clk);
      lat = 1;
      cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      cmd_rw = ~rw; cmd_dev_addr = ~dev; cmd_mem_addr = ~mem; cmd_wdata = ~wd;
      while (!rv(b) && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int stops;
      logic seen;

      rst_n = 1'b0;
      cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      cmd_rw = 1'b0; cmd_dev_addr = 7'h00; cmd_mem_addr = 8'h00; cmd_wdata = 16'h0000;
      ack_en[0] = 4'hF; ack_en[1] = 4'hF;
      sl_rdata[0] = 16'h1234; sl_rdata[1] = 16'h0000;
      repeat (3) @(negedge clk);

      chk("rst_ready",  cmd_ready0, 1);
      chk("rst_busy",   busy0, 0);
      chk("rst_valid",  rsp_valid0, 0);
      chk("rst_nack",   rsp_nack0, 0);
      chk("rst_rdata",  rsp_rdata0, 16'h0000);
      chk("rst_scl",    scl0, 1);
      chk("rst_sda",    sda0, 1);
      chk("rst_ready1", cmd_ready1, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // write 0xABCD to 0x12 on device 0x2A
      do_cmd(0, 1'b0, 7'h2A, 8'h12, 16'hABCD, lat);
      chk("wr_lat",  lat, 609);
      chk("wr_nack", rsp_nack0, 0);
      chk("wr_nb",   g_slv[0].nbytes, 4);
      chk("wr_b0",   g_slv[0].bytes[0], 8'h54);
      chk("wr_b1",   g_slv[0].bytes[1], 8'h12);
      chk("wr_b2",   g_slv[0].bytes[2], 8'hAB);
      chk("wr_b3",   g_slv[0].bytes[3], 8'hCD);
      chk("wr_busy", busy0, 1);
      @(negedge clk);
      chk("wr_pulse", rsp_valid0, 0);
      chk("wr_ready", cmd_ready0, 1);

      // read from 0x05, slave returns 0x1234
      do_cmd(0, 1'b1, 7'h2A, 8'h05, 16'h0000, lat);
      chk("rd_lat",   lat, 609);
      chk("rd_nack",  rsp_nack0, 0);
      chk("rd_data",  rsp_rdata0, 16'h1234);
      chk("rd_b0",    g_slv[0].bytes[0], 8'h55);
      chk("rd_b1",    g_slv[0].bytes[1], 8'h05);
      chk("rd_b2",    g_slv[0].bytes[2], 8'h12);
      chk("rd_b3",    g_slv[0].bytes[3], 8'h34);
      chk("rd_mack",  g_slv[0].acks[2], 0);
      chk("rd_mnack", g_slv[0].acks[3], 1);

      // no slave present
      ack_en[0] = 4'h0;
      stops = g_slv[0].nstops;
      do_cmd(0, 1'b0, 7'h2A, 8'h12, 16'hABCD, lat);
      chk("ns_lat",   lat, 177);
      chk("ns_nack",  rsp_nack0, 1);
      chk("ns_rdata", rsp_rdata0, 16'h1234);
      chk("ns_nb",    g_slv[0].nbytes, 1);
      chk("ns_stop",  g_slv[0].nstops, stops + 1);

      // slave NACKs data bytes, data ACK not checked
      ack_en[0] = 4'b0011;
      do_cmd(0, 1'b0, 7'h2A, 8'h33, 16'h5A0F, lat);
      chk("dn0_lat",  lat, 609);
      chk("dn0_nack", rsp_nack0, 0);
      chk("dn0_b2",   g_slv[0].bytes[2], 8'h5A);
      chk("dn0_b3",   g_slv[0].bytes[3], 8'h0F);
      chk("dn0_ack2", g_slv[0].acks[2], 1);

      // same slave, data ACK checked: abort after WR_HI_ACK (29 slots)
      ack_en[1] = 4'b0011;
      do_cmd(1, 1'b0, 7'h2A, 8'h33, 16'h5A0F, lat);
      chk("dn1_lat",  lat, 465);
      chk("dn1_nack", rsp_nack1, 1);
      chk("dn1_nb",   g_slv[1].nbytes, 3);

      // reset during WR_LO (slot 28, second clk of Q0)
      ack_en[0] = 4'hF;
      @(negedge clk);
      cmd_rw = 1'b0; cmd_dev_addr = 7'h2A; cmd_mem_addr = 8'h44; cmd_wdata = 16'h9A3C;
      cmd_valid0 = 1'b1;
      @(negedge clk);
      lat = 1;
      cmd_valid0 = 1'b0;
      while (lat < 450) begin
         @(negedge clk);
         lat++;
      end
      chk("mr_scl_pre", scl0, 0);
      chk("mr_sda_pre", sda0, 0);
      stops = g_slv[0].nstops;
      rst_n = 1'b0;
      #1;
      chk("mr_scl",   scl0, 1);
      chk("mr_sda",   sda0, 1);
      chk("mr_busy",  busy0, 0);
      chk("mr_ready", cmd_ready0, 1);
      chk("mr_rdata", rsp_rdata0, 16'h0000);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | rsp_valid0;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         seen = seen | rsp_valid0;
      end
      chk("mr_norsp",  seen, 0);
      chk("mr_nostop", g_slv[0].nstops, stops);

      do_cmd(0, 1'b0, 7'h2A, 8'h44, 16'h1357, lat);
      chk("ar_lat",  lat, 609);
      chk("ar_nack", rsp_nack0, 0);
      chk("ar_b2",   g_slv[0].bytes[2], 8'h13);
      chk("ar_b3",   g_slv[0].bytes[3], 8'h57);

      // two back-to-back commands with cmd_valid held high
      sl_rdata[0] = 16'hBEEF;
      @(negedge clk);
      cmd_rw = 1'b0; cmd_dev_addr = 7'h2A; cmd_mem_addr = 8'h10; cmd_wdata = 16'h0102;
      cmd_valid0 = 1'b1;
      @(negedge clk);
      lat = 1;
      cmd_rw = 1'b1; cmd_mem_addr = 8'h20; cmd_wdata = 16'hFFFF;
      chk("q_busy",  busy0, 1);
      chk("q_ready", cmd_ready0, 0);
      while (!rsp_valid0 && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      chk("q1_lat", lat, 609);
      chk("q1_b1",  g_slv[0].bytes[1], 8'h10);
      chk("q1_b2",  g_slv[0].bytes[2], 8'h01);
      chk("q1_b3",  g_slv[0].bytes[3], 8'h02);
      @(negedge clk);
      chk("q_gap_ready", cmd_ready0, 1);
      @(negedge clk);
      chk("q2_busy", busy0, 1);
      cmd_valid0 = 1'b0;
      lat = 1;
      while (!rsp_valid0 && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      chk("q2_lat",   lat, 609);
      chk("q2_b0",    g_slv[0].bytes[0], 8'h55);
      chk("q2_b1",    g_slv[0].bytes[1], 8'h20);
      chk("q2_rdata", rsp_rdata0, 16'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_sram_master.md
I2C_SRAM_MASTER -- requirements
Module: i2c_sram_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-phase, legal range >=1.
REQ-002 SHALL have parameter CHECK_DATA_ACK, default 0: 1 = slave NACK on memory-address/data bytes aborts; 0 = only the device-address ACK is checked.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are as follows.
REQ-004 clk  input  1  system clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-008 cmd_rw  input  1  0 = SRAM write, 1 = SRAM read (sent as the I2C mode bit).
REQ-009 cmd_dev_addr  input  7  target slave address.
REQ-010 cmd_mem_addr  input  8  SRAM word address.
REQ-011 cmd_wdata  input  16  write data, high byte sent first.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_nack  output  1  valid with rsp_valid; 1 = transaction aborted on NACK.
REQ-014 rsp_rdata  output  16  read data; updated only on a completed, non-aborted read.
REQ-015 busy  output  1  high from acceptance through the rsp_valid cycle.
REQ-016 scl  output  1  I2C clock, push-pull, idle 1.
REQ-017 sda  inout  1  open-drain: driven 0 or released (Z), never driven 1; sampled directly.

Function
REQ-018 Command fields SHALL be latched on acceptance; input changes afterwards SHALL have no effect.
REQ-019 Bit timing: each bit slot SHALL be 4 quarter-phases of CLK_DIV clks; SCL is low in Q0–Q1 and high in Q2–Q3; SDA changes only at the start of Q0; SDA is sampled on the last clk of Q2.
REQ-020 START slot: SCL high throughout Q0–Q2, SDA released in Q0 and driven 0 from Q1; SCL low in Q3.
REQ-021 STOP slot: SDA driven 0 in Q0–Q1 with SCL low in Q0 and high from Q1; SDA released at Q2 while SCL stays high.
REQ-022 FSM states: IDLE, START, DEV (8 bits: address MSB first, then mode bit), DEV_ACK, MADDR, MADDR_ACK, WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK, RD_HI, RD_HI_MACK, RD_LO, RD_LO_MACK, STOP, DONE.
REQ-023 Transitions: IDLE→START on accept; START→DEV→DEV_ACK→MADDR→MADDR_ACK.
REQ-024 From MADDR_ACK: cmd_rw=0 → WR_HI→WR_HI_ACK→WR_LO→WR_LO_ACK→STOP; cmd_rw=1 → RD_HI→RD_HI_MACK→RD_LO→RD_LO_MACK→STOP.
REQ-025 STOP→DONE→IDLE; DONE SHALL last one clk and assert rsp_valid.
REQ-026 In slave-ACK slots, SDA SHALL be released; sampled 1 = NACK.
REQ-027 A NACK in DEV_ACK, or in any slave-ACK slot when CHECK_DATA_ACK=1, SHALL branch to STOP and set rsp_nack=1.
REQ-028 In read-data slots, SDA SHALL be released and sampled bits shifted in MSB first.
REQ-029 The master SHALL drive ACK (0) in RD_HI_MACK and NACK (released) in RD_LO_MACK.
REQ-030 Latency: a full read or write SHALL span 38 bit slots; rsp_valid SHALL assert 38*4*CLK_DIV+1 clks after the accept edge (609 at CLK_DIV=4).
REQ-031 Latency: a DEV_ACK abort SHALL span 11 slots, with rsp_valid at 11*4*CLK_DIV+1 clks.
REQ-032 cmd_ready SHALL be 0 from the accept edge until the clk after rsp_valid; cmd_valid while busy SHALL be ignored.
REQ-033 The quarter and bit counters SHALL wrap exactly at CLK_DIV-1 and 3, with no extra idle cycles between slots.

Reset
REQ-034 On reset low, immediately and asynchronously: state=IDLE, scl=1, sda released, cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_rdata=16'h0000, all counters 0.
REQ-035 Reset mid-transaction SHALL abandon the transaction without generating a STOP or a rsp_valid.

Verification
REQ-036 CLK_DIV=4, write dev=0x2A, mem=0x12, wdata=0xABCD, ACKing slave model -> bus bytes 0x54, 0x12, 0xAB, 0xCD between START and STOP; rsp_valid at clk 609 with rsp_nack=0.
REQ-037 Read dev=0x2A, mem=0x05, slave returns 0x1234 -> first byte 0x55; master ACK after 0x12 and NACK after 0x34; rsp_rdata=0x1234.
REQ-038 No slave present (SDA pulled up) -> STOP after the 9th bit; rsp_nack=1 at clk 177; rsp_rdata unchanged.
REQ-039 CHECK_DATA_ACK=0 with a slave that releases SDA on data ACKs -> write completes with rsp_nack=0. CHECK_DATA_ACK=1, same slave -> abort after WR_HI_ACK with rsp_nack=1.
REQ-040 Reset asserted during WR_LO -> scl=1 and sda=Z in the same timestep; no rsp_valid. A new command after release completes normally.
REQ-041 cmd_valid held high with two queued commands -> second accepted exactly one clk after the first rsp_valid; inputs changed mid-transaction do not alter the bus bytes.
